// File: rtl/dff_updown_counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter family.
package dff_updown_counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DN   = 1'b0;
  localparam int   CNT_WRAP = 0;
  localparam int   CNT_SAT  = 1;

  // Callers cast the result down to their own width.
  function automatic logic [63:0] bin2gray(input logic [63:0] i_bin);
    return i_bin ^ (i_bin >> 1);
  endfunction

endpackage

// File: rtl/dff_updown_counter_dff_reg.sv
// Plain WIDTH-bit register with asynchronous active-low reset to RESET_VAL.
module dff_reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/dff_updown_counter.sv
// Up/down modulo counter with clear, clamped load, wrap or saturate limits,
// terminal count, wrap/saturate indications and a registered Gray copy.
module dff_updown_counter
  import dff_updown_counter_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_VAL   = '1,
  parameter int               SATURATE  = CNT_WRAP,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_gray,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] GRAY_RST = WIDTH'(bin2gray(64'(RESET_VAL)));

  logic [WIDTH-1:0] w_count_next;
  logic [WIDTH-1:0] w_gray_next;
  logic             w_wrap_next;
  logic             w_sat_next;
  logic             w_at_max;
  logic             w_at_zero;
  logic [1:0]       w_flag_next;
  logic [1:0]       w_flag_q;

  assign w_at_max  = (count == MAX_VAL);
  assign w_at_zero = (count == '0);

  // Limits are tested before the +/-1 so the arithmetic never overflows.
  always_comb begin
    w_count_next = count;
    w_wrap_next  = 1'b0;
    w_sat_next   = 1'b0;
    if (clear) begin
      w_count_next = RESET_VAL;
    end else if (load) begin
      w_count_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (up_dn == CNT_UP) begin
        if (!w_at_max) begin
          w_count_next = count + WIDTH'(1);
        end else if (SATURATE == CNT_SAT) begin
          w_sat_next = 1'b1;
        end else begin
          w_count_next = '0;
          w_wrap_next  = 1'b1;
        end
      end else begin
        if (!w_at_zero) begin
          w_count_next = count - WIDTH'(1);
        end else if (SATURATE == CNT_SAT) begin
          w_sat_next = 1'b1;
        end else begin
          w_count_next = MAX_VAL;
          w_wrap_next  = 1'b1;
        end
      end
    end
  end

  assign w_gray_next = WIDTH'(bin2gray(64'(w_count_next)));
  assign tc = en & ((up_dn & w_at_max) | (~up_dn & w_at_zero));

  dff_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_count_reg (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     (w_count_next),
    .o_q     (count)
  );

  // Gray copy is taken from the next count so it moves on the same edge.
  dff_reg #(.WIDTH(WIDTH), .RESET_VAL(GRAY_RST)) u_gray_reg (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     (w_gray_next),
    .o_q     (count_gray)
  );

  assign w_flag_next = {w_sat_next, w_wrap_next};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_flag
      dff_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_flag_reg (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_d     (w_flag_next[gi]),
        .o_q     (w_flag_q[gi])
      );
    end
  endgenerate

  assign wrap = w_flag_q[0];
  assign sat  = w_flag_q[1];

endmodule

// File: tb/tb_dff_updown_counter.sv
// Scoreboard bench: three counter configurations driven by shared stimulus.
module tb_dff_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, clear, load, en, up_dn;
  logic [3:0] load_val;
  logic [2:0] load_val_c;
  assign load_val_c = load_val[2:0];

  logic [3:0] a_cnt, a_gray, b_cnt, b_gray;
  logic [2:0] c_cnt, c_gray;
  logic       a_tc, a_wrap, a_sat, b_tc, b_wrap, b_sat, c_tc, c_wrap, c_sat;

  dff_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(0), .RESET_VAL(4'd0)) dut_a (
    .clk(clk), .reset_n(reset_n), .clear(clear), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(a_cnt), .count_gray(a_gray), .tc(a_tc), .wrap(a_wrap), .sat(a_sat));

  dff_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1), .RESET_VAL(4'd0)) dut_b (
    .clk(clk), .reset_n(reset_n), .clear(clear), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(b_cnt), .count_gray(b_gray), .tc(b_tc), .wrap(b_wrap), .sat(b_sat));

  dff_updown_counter #(.WIDTH(3), .MAX_VAL(3'd7), .SATURATE(0), .RESET_VAL(3'd0)) dut_c (
    .clk(clk), .reset_n(reset_n), .clear(clear), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val_c), .count(c_cnt), .count_gray(c_gray), .tc(c_tc), .wrap(c_wrap), .sat(c_sat));

  typedef struct {int tag; int d; int cnt; int w; int s;} st_t;
  typedef struct {int tag; int d; int tc;} tc_t;
  st_t sq[$];
  tc_t tq[$];

  int maxv[3]  = '{9, 9, 7};
  int satm[3]  = '{0, 1, 0};
  int lvmask[3] = '{15, 15, 7};
  int m_cnt[3] = '{0, 0, 0};

  int n_vec = 0, n_miss = 0, edge_cnt = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // sel: 0 count, 1 gray, 2 wrap, 3 sat, 4 tc
  function automatic integer get(int d, int sel);
    integer v;
    v = 0;
    case (d)
      0: case (sel) 0: v = a_cnt; 1: v = a_gray; 2: v = a_wrap; 3: v = a_sat; default: v = a_tc; endcase
      1: case (sel) 0: v = b_cnt; 1: v = b_gray; 2: v = b_wrap; 3: v = b_sat; default: v = b_tc; endcase
      default: case (sel) 0: v = c_cnt; 1: v = c_gray; 2: v = c_wrap; 3: v = c_sat; default: v = c_tc; endcase
    endcase
    return v;
  endfunction

  task automatic check(string name, int d, integer act, integer exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s dut%0d t=%0t: got %0d, expected %0d", name, d, $time, act, exp);
    end
  endtask

  initial begin
    st_t s;
    tc_t t;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        while (tq.size() > 0 && tq[0].tag <= edge_cnt) begin
          t = tq.pop_front();
          check("tc", t.d, get(t.d, 4), t.tc);
        end
        while (sq.size() > 0 && sq[0].tag <= edge_cnt) begin
          s = sq.pop_front();
          check("count", s.d, get(s.d, 0), s.cnt);
          check("gray",  s.d, get(s.d, 1), s.cnt ^ (s.cnt >> 1));
          check("wrap",  s.d, get(s.d, 2), s.w);
          check("sat",   s.d, get(s.d, 3), s.s);
          $display("edge %0d dut%0d: count=%0d wrap=%0d sat=%0d", s.tag, s.d, s.cnt, s.w, s.s);
        end
      end
    end
  end

  // Reference: modular arithmetic for wrap mode, min/max clamping for saturate mode.
  task automatic cycle(bit clr, bit ld, int lv, bit e, bit up);
    int old, mx, c, w, s, v;
    clear = clr; load = ld; load_val = lv[3:0]; en = e; up_dn = up;
    for (int d = 0; d < 3; d++) begin
      old = m_cnt[d];
      mx  = maxv[d];
      tq.push_back('{edge_cnt, d, int'(e && ((up && old == mx) || (!up && old == 0)))});
      c = old; w = 0; s = 0;
      if (clr) begin
        c = 0;
      end else if (ld) begin
        v = lv & lvmask[d];
        c = (v > mx) ? mx : v;
      end else if (e) begin
        if (satm[d] == 0) begin
          c = up ? (old + 1) % (mx + 1) : (old + mx) % (mx + 1);
          w = up ? int'(old == mx) : int'(old == 0);
        end else begin
          c = up ? ((old + 1 > mx) ? mx : old + 1) : ((old - 1 < 0) ? 0 : old - 1);
          s = up ? int'(old + 1 > mx) : int'(old - 1 < 0);
        end
      end
      sq.push_back('{edge_cnt + 1, d, c, w, s});
      m_cnt[d] = c;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(string name);
    for (int d = 0; d < 3; d++) begin
      check({name, "_count"}, d, get(d, 0), 0);
      check({name, "_gray"},  d, get(d, 1), 0);
      check({name, "_wrap"},  d, get(d, 2), 0);
      check({name, "_sat"},   d, get(d, 3), 0);
    end
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; load = 1'b0; en = 1'b0; up_dn = 1'b0; load_val = '0;
    #2;
    check_reset_state("por");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    repeat (11) cycle(0, 0, 0, 1, 1);      // up-count through the limit
    cycle(0, 1, 2, 0, 0);
    repeat (4) cycle(0, 0, 0, 1, 0);       // down through zero
    cycle(0, 1, 8, 0, 1);
    repeat (3) cycle(0, 0, 0, 1, 1);       // saturate at top (dut_b)
    cycle(0, 0, 0, 1, 0);
    cycle(1, 1, 5, 1, 1);                  // clear beats load and en
    cycle(0, 1, 15, 1, 1);                 // clamp
    repeat (3) cycle(0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    repeat (6) cycle(0, 0, 0, 1, 1);

    // Drop reset between edges with count at 6.
    @(negedge clk); #1;
    check("pre_reset_count", 0, get(0, 0), 6);
    reset_n = 1'b0;
    mon_en = 1'b0;
    #1;
    check_reset_state("async");
    sq.delete();
    tq.delete();
    for (int d = 0; d < 3; d++) m_cnt[d] = 0;
    @(posedge clk); #1;
    check_reset_state("held");
    reset_n = 1'b1;
    mon_en = 1'b1;
    cycle(0, 0, 0, 1, 1);
    repeat (10) cycle(0, 0, 0, 1, 1);

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 16) == 0, ($urandom % 8) == 0, int'($urandom % 16),
            ($urandom % 4) != 0, ($urandom % 3) != 0);
    end

    @(negedge clk); #1;
    if (sq.size() != 0 || tq.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: got %0d pending items, expected 0", sq.size() + tq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
